// File: rtl/composite_sync_gen.sv
// rtl/composite_sync_gen.sv - NTSC-style 240p timing and composite sync generator
// Outputs are registered decodes of (h,v), one enabled cycle behind the counters.
module composite_sync_gen #(
  parameter int H_TOTAL     = 858,
  parameter int HSYNC_LEN   = 63,
  parameter int BURST_START = 72,
  parameter int BURST_LEN   = 34,
  parameter int ACT_START   = 122,
  parameter int ACT_LEN     = 720,
  parameter int V_TOTAL     = 262,
  parameter int VSYNC_START = 3,
  parameter int VSYNC_LINES = 3,
  parameter int VACT_START  = 21,
  parameter int VACT_LEN    = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic       sync_n,
  output logic       blank,
  output logic       burst,
  output logic       active,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_END    = 10'(HSYNC_LEN);
  localparam logic [9:0] BROAD_END = 10'(H_TOTAL - HSYNC_LEN);
  localparam logic [9:0] B_START   = 10'(BURST_START);
  localparam logic [9:0] B_END     = 10'(BURST_START + BURST_LEN);
  localparam logic [9:0] A_START   = 10'(ACT_START);
  localparam logic [9:0] A_END     = 10'(ACT_START + ACT_LEN);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] VS_START  = 9'(VSYNC_START);
  localparam logic [8:0] VS_END    = 9'(VSYNC_START + VSYNC_LINES);
  localparam logic [8:0] VA_START  = 9'(VACT_START);
  localparam logic [8:0] VA_END    = 9'(VACT_START + VACT_LEN);

  localparam bit PARAMS_OK = (HSYNC_LEN < BURST_START) &&
                             (BURST_START + BURST_LEN <= ACT_START) &&
                             (ACT_START + ACT_LEN <= H_TOTAL) &&
                             (VACT_START + VACT_LEN <= V_TOTAL);

  logic [9:0] h;
  logic [8:0] v;

  logic       vsync_line;
  logic       sync_n_d;
  logic       burst_d;
  logic       active_d;
  logic [9:0] x_d;
  logic [8:0] y_d;

  always_comb begin
    vsync_line = (v >= VS_START) && (v < VS_END);
    // Vsync lines carry one broad pulse covering all but the last HSYNC_LEN clocks.
    sync_n_d   = vsync_line ? (h >= BROAD_END) : (h >= HS_END);
    burst_d    = !vsync_line && (h >= B_START) && (h < B_END);
    active_d   = (h >= A_START) && (h < A_END) && (v >= VA_START) && (v < VA_END);
    x_d        = active_d ? (h - A_START) : 10'd0;
    y_d        = active_d ? (v - VA_START) : 9'd0;
  end

  always_ff @(posedge clk) begin
    assert (PARAMS_OK) else $error("composite_sync_gen: unsupported timing parameter set");
    if (reset) begin
      h           <= 10'd0;
      v           <= 9'd0;
      sync_n      <= 1'b1;
      blank       <= 1'b1;
      burst       <= 1'b0;
      active      <= 1'b0;
      x           <= 10'd0;
      y           <= 9'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      if (h == H_LAST) begin
        h <= 10'd0;
        v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
      end else begin
        h <= h + 10'd1;
      end
      sync_n      <= sync_n_d;
      blank       <= !active_d;
      burst       <= burst_d;
      active      <= active_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= (h == 10'd0);
      frame_start <= (h == 10'd0) && (v == 9'd0);
    end
  end

endmodule

// File: tb/tb_composite_sync_gen.sv
// tb/tb_composite_sync_gen.sv - self-checking bench for composite_sync_gen
// Vertical timing is shortened (40 lines) so a whole frame fits in a short run.
module tb_composite_sync_gen;

  localparam int HT = 858, HS = 63, BS = 72, BL = 34, AS = 122, AL = 720;
  localparam int VT = 40, VSS = 3, VSL = 3, VAS = 21, VAL = 16;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic       sync_n, blank, burst, active, line_start, frame_start;
  logic [9:0] x;
  logic [8:0] y;

  typedef struct packed {
    logic       sync_n;
    logic       blank;
    logic       burst;
    logic       active;
    logic [9:0] x;
    logic [8:0] y;
    logic       ls;
    logic       fs;
  } outs_t;

  composite_sync_gen #(
    .H_TOTAL(HT), .HSYNC_LEN(HS), .BURST_START(BS), .BURST_LEN(BL),
    .ACT_START(AS), .ACT_LEN(AL), .V_TOTAL(VT), .VSYNC_START(VSS),
    .VSYNC_LINES(VSL), .VACT_START(VAS), .VACT_LEN(VAL)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .sync_n(sync_n), .blank(blank),
    .burst(burst), .active(active), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  outs_t act;
  assign act = {sync_n, blank, burst, active, x, y, line_start, frame_start};

  function automatic outs_t reset_outs();
    outs_t o;
    o = '0;
    o.sync_n = 1'b1;
    o.blank  = 1'b1;
    return o;
  endfunction

  // Outputs for a linear frame position p = v*HT + h.
  function automatic outs_t decode(int p);
    outs_t o;
    int h, v;
    bit vs;
    h = p % HT;
    v = p / HT;
    vs = (v >= VSS) && (v < VSS + VSL);
    o.sync_n = vs ? (h >= HT - HS) : (h >= HS);
    o.burst  = !vs && (h >= BS) && (h < BS + BL);
    o.active = (h >= AS) && (h < AS + AL) && (v >= VAS) && (v < VAS + VAL);
    o.blank  = !o.active;
    o.x      = o.active ? 10'(h - AS) : 10'd0;
    o.y      = o.active ? 9'(v - VAS) : 9'd0;
    o.ls     = (h == 0);
    o.fs     = (p == 0);
    return o;
  endfunction

  outs_t exp_o;
  int    mp = 0;
  bit    mvalid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_o  = reset_outs();
      mp     = 0;
      mvalid = 1'b1;
    end else if (ce) begin
      exp_o = decode(mp);
      mp    = (mp + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (act === exp_o) passed++;
      else $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp_o);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  int    sl[VT];
  int    bu[VT];
  int    act_tot, a30, xerr, yerr, first_b, last_b, ls_prev, ls_cnt, lserr, fserr;
  int    xs_n, xseq_err, hold_err, ls_first_i;
  outs_t prev;

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    repeat (5) cyc();
    chk("reset_state", int'(act), int'(reset_outs()));

    reset = 1'b0;
    cyc();
    chk("first_fs", int'(frame_start), 1);
    chk("first_ls", int'(line_start), 1);
    chk("first_sync_n", int'(sync_n), 0);

    foreach (sl[i]) begin sl[i] = 0; bu[i] = 0; end
    act_tot = 0; a30 = 0; xerr = 0; yerr = 0; first_b = -1; last_b = -1;
    ls_prev = -1; ls_cnt = 0; lserr = 0; fserr = 0;
    for (int k = 0; k < FRAME; k++) begin
      int ln, hh;
      ln = k / HT;
      hh = k % HT;
      if (!sync_n) sl[ln]++;
      if (burst) begin
        bu[ln]++;
        if (ln == 30) begin
          if (first_b < 0) first_b = hh;
          last_b = hh;
        end
      end
      if (active) begin
        act_tot++;
        if (ln == 30) begin
          a30++;
          if (int'(x) != hh - AS) xerr++;
          if (int'(y) != 9) yerr++;
        end
      end
      if (line_start) begin
        if (ls_prev >= 0 && k - ls_prev != HT) lserr++;
        ls_prev = k;
        ls_cnt++;
      end
      if (frame_start && k != 0) fserr++;
      cyc();
    end
    chk("l30_sync_low", sl[30], 63);
    chk("l30_burst_len", bu[30], 34);
    chk("l30_burst_first", first_b, 72);
    chk("l30_burst_last", last_b, 105);
    chk("l30_active_len", a30, 720);
    chk("l30_x_seq_err", xerr, 0);
    chk("l30_y_err", yerr, 0);
    chk("ls_period_err", lserr, 0);
    chk("ls_per_frame", ls_cnt, VT);
    chk("fs_extra", fserr, 0);
    for (int ln = VSS; ln < VSS + VSL; ln++) begin
      chk("vsync_sync_low", sl[ln], 795);
      chk("vsync_burst", bu[ln], 0);
    end
    chk("frame_active_total", act_tot, VAL * 720);
    chk("wrap_fs", int'(frame_start), 1);
    chk("wrap_ls", int'(line_start), 1);
    chk("wrap_sync_n", int'(sync_n), 0);

    repeat (VAS * HT) cyc();
    chk("pre_toggle_ls", int'(line_start), 1);
    xs_n = 0; xseq_err = 0; hold_err = 0; ls_first_i = -1;
    for (int i = 0; i < 2 * HT; i++) begin
      ce   = (i % 2 == 0);
      prev = act;
      cyc();
      if (!ce) begin
        if (act !== prev) hold_err++;
      end else begin
        if (active) begin
          if (int'(x) != xs_n) xseq_err++;
          xs_n++;
        end
        if (line_start && ls_first_i < 0) ls_first_i = i;
      end
    end
    ce = 1'b1;
    chk("toggle_hold_err", hold_err, 0);
    chk("toggle_x_count", xs_n, 720);
    chk("toggle_x_seq_err", xseq_err, 0);
    chk("toggle_line_clocks", ls_first_i, 2 * HT - 2);
    chk("toggle_end_ls", int'(line_start), 1);

    repeat (400) cyc();
    chk("mid_active_x", int'(x), 400 - AS);
    reset = 1'b1;
    ce    = 1'b0;
    cyc();
    chk("mid_reset_state", int'(act), int'(reset_outs()));
    reset = 1'b0;
    cyc();
    chk("post_reset_hold", int'(act), int'(reset_outs()));
    ce = 1'b1;
    cyc();
    chk("post_reset_fs", int'(frame_start), 1);
    chk("post_reset_ls", int'(line_start), 1);

    repeat (3000) begin
      ce    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc();
    end
    reset = 1'b0;
    ce    = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
